// File: rtl/fpu_ss_pkg.sv
// fpu_ss_pkg: shared types and helpers for the FPU subsystem hazard/commit logic.
package fpu_ss_pkg;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        COMMITTED = 2'd1,
        KILLED    = 2'd2
    } commit_state_e;

    // Select encodes 0 = regfile, p+1 = write-back port p.
    function automatic int fwd_sel_width(input int num_wb);
        return (num_wb < 1) ? 1 : $clog2(num_wb + 1);
    endfunction

endpackage

// File: rtl/fpu_ss_id_table.sv
// fpu_ss_id_table: per-offload-ID commit/kill state with a combinational head lookup.
module fpu_ss_id_table
    import fpu_ss_pkg::*;
#(
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                commit_valid,
    input  logic [ID_WIDTH-1:0] commit_id,
    input  logic                commit_kill,
    input  logic                head_valid,
    input  logic [ID_WIDTH-1:0] head_id,
    input  logic                clear,
    output logic                head_commit_ok,
    output logic                head_kill
);

    localparam int unsigned DEPTH = 2 ** ID_WIDTH;

    commit_state_e table_q [DEPTH];
    commit_state_e head_state;
    logic          same_id;

    // The commit write comes last so it wins over a same-cycle clear of the same ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) table_q[i] <= NONE;
        end else if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) table_q[i] <= NONE;
        end else begin
            if (clear) table_q[head_id] <= NONE;
            if (commit_valid) table_q[commit_id] <= commit_kill ? KILLED : COMMITTED;
        end
    end

    assign head_state     = table_q[head_id];
    assign same_id        = commit_valid && (commit_id == head_id);
    assign head_commit_ok = head_valid && (head_state == COMMITTED || (same_id && !commit_kill));
    assign head_kill      = head_valid && (head_state == KILLED || (same_id && commit_kill));

endmodule

// File: rtl/fpu_ss_hazard_unit.sv
// fpu_ss_hazard_unit: FP destination scoreboard, multi-port write-back forwarding,
// in-flight limiting and commit-gated issue for the FPU input-buffer head.
module fpu_ss_hazard_unit
    import fpu_ss_pkg::*;
#(
    parameter int unsigned  NUM_FPR      = 32,
    parameter int unsigned  ID_WIDTH     = 4,
    parameter int unsigned  NUM_WB       = 2,
    parameter int unsigned  MAX_INFLIGHT = 4,
    parameter bit           OUT_OF_ORDER = 1'b1,
    parameter bit           FORWARDING   = 1'b1,
    localparam int unsigned AW           = $clog2(NUM_FPR),
    localparam int unsigned FW           = fwd_sel_width(NUM_WB),
    localparam int unsigned CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   commit_valid_i,
    input  logic [ID_WIDTH-1:0]    commit_id_i,
    input  logic                   commit_kill_i,
    input  logic                   head_valid_i,
    input  logic [ID_WIDTH-1:0]    head_id_i,
    input  logic [3*AW-1:0]        rs_addr_i,
    input  logic [2:0]             rs_use_i,
    input  logic [AW-1:0]          rd_addr_i,
    input  logic                   rd_is_fp_i,
    input  logic                   dispatch_i,
    input  logic                   drop_i,
    input  logic [NUM_WB-1:0]      wb_valid_i,
    input  logic [NUM_WB-1:0]      wb_we_i,
    input  logic [NUM_WB*AW-1:0]   wb_addr_i,
    output logic                   dep_rs_o,
    output logic                   dep_rd_o,
    output logic [3*FW-1:0]        fwd_sel_o,
    output logic                   head_commit_ok_o,
    output logic                   head_kill_o,
    output logic                   inflight_full_o,
    output logic                   issue_ok_o,
    output logic [CW-1:0]          inflight_cnt_o
);

    localparam int LIMIT = OUT_OF_ORDER ? int'(MAX_INFLIGHT) : 1;

    logic [NUM_FPR-1:0] sb_q;
    logic [NUM_FPR-1:0] sb_set;
    logic [NUM_FPR-1:0] sb_clr;
    logic [3*FW-1:0]    fwd;
    logic               dep_rs;
    logic [CW-1:0]      cnt_q;
    int                 pending;
    int                 cnt_raw;
    int                 cnt_next;

    fpu_ss_id_table #(
        .ID_WIDTH(ID_WIDTH)
    ) u_id_table (
        .clk           (clk_i),
        .rst_n         (rst_ni),
        .flush         (flush_i),
        .commit_valid  (commit_valid_i),
        .commit_id     (commit_id_i),
        .commit_kill   (commit_kill_i),
        .head_valid    (head_valid_i),
        .head_id       (head_id_i),
        .clear         (dispatch_i | drop_i),
        .head_commit_ok(head_commit_ok_o),
        .head_kill     (head_kill_o)
    );

    always_comb begin
        sb_clr = '0;
        for (int p = 0; p < int'(NUM_WB); p++)
            if (wb_valid_i[p] && wb_we_i[p]) sb_clr[wb_addr_i[p*AW +: AW]] = 1'b1;
        sb_set = '0;
        if (dispatch_i && rd_is_fp_i) sb_set[rd_addr_i] = 1'b1;
    end

    // Ports are scanned high to low so the lowest matching port is written last.
    always_comb begin
        fwd    = '0;
        dep_rs = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int p = int'(NUM_WB) - 1; p >= 0; p--)
                if (FORWARDING && rs_use_i[k] && wb_valid_i[p] && wb_we_i[p] &&
                    wb_addr_i[p*AW +: AW] == rs_addr_i[k*AW +: AW])
                    fwd[k*FW +: FW] = FW'(p + 1);
            if (rs_use_i[k] && sb_q[rs_addr_i[k*AW +: AW]] && fwd[k*FW +: FW] == '0)
                dep_rs = 1'b1;
        end
    end

    always_comb begin
        pending = int'(cnt_q);
        for (int p = 0; p < int'(NUM_WB); p++) pending = pending - int'(wb_valid_i[p]);
        cnt_raw  = pending + int'(dispatch_i);
        cnt_next = (cnt_raw < 0) ? 0 : ((cnt_raw > LIMIT) ? LIMIT : cnt_raw);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= (sb_q & ~sb_clr) | sb_set;
            cnt_q <= CW'(cnt_next);
        end
    end

    // More retires than operations in flight means the dispatch bookkeeping is broken.
    always_ff @(posedge clk_i)
        if (rst_ni && !flush_i) assert (cnt_raw >= 0);

    assign fwd_sel_o       = fwd;
    assign dep_rs_o        = head_valid_i & dep_rs;
    assign dep_rd_o        = head_valid_i & rd_is_fp_i & sb_q[rd_addr_i] & ~sb_clr[rd_addr_i];
    assign inflight_full_o = pending >= LIMIT;
    assign inflight_cnt_o  = cnt_q;
    assign issue_ok_o      = head_valid_i & head_commit_ok_o & ~dep_rs_o & ~dep_rd_o & ~inflight_full_o;

endmodule

// File: tb/tb_fpu_ss_hazard_unit.sv
// tb_fpu_ss_hazard_unit: directed checks on default, no-forwarding and in-order
// configurations of the hazard unit.
module tb_fpu_ss_hazard_unit;

    typedef struct packed {
        logic        flush;
        logic        cv;
        logic [3:0]  cid;
        logic        ck;
        logic        hv;
        logic [3:0]  hid;
        logic [14:0] rs;
        logic [2:0]  ruse;
        logic [4:0]  rd;
        logic        rdfp;
        logic        disp;
        logic        drop;
        logic [1:0]  wbv;
        logic [1:0]  wbw;
        logic [9:0]  wba;
    } in_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    in_t        di [3];
    logic       dep_rs [3];
    logic       dep_rd [3];
    logic [5:0] fwd [3];
    logic       hco [3];
    logic       hk [3];
    logic       full [3];
    logic       iok [3];
    logic [2:0] cnt [3];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: FORWARDING=0; 2: OUT_OF_ORDER=0.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        fpu_ss_hazard_unit #(
            .FORWARDING  (g != 1),
            .OUT_OF_ORDER(g != 2)
        ) u_dut (
            .clk_i           (clk),
            .rst_ni          (rst_n),
            .flush_i         (di[g].flush),
            .commit_valid_i  (di[g].cv),
            .commit_id_i     (di[g].cid),
            .commit_kill_i   (di[g].ck),
            .head_valid_i    (di[g].hv),
            .head_id_i       (di[g].hid),
            .rs_addr_i       (di[g].rs),
            .rs_use_i        (di[g].ruse),
            .rd_addr_i       (di[g].rd),
            .rd_is_fp_i      (di[g].rdfp),
            .dispatch_i      (di[g].disp),
            .drop_i          (di[g].drop),
            .wb_valid_i      (di[g].wbv),
            .wb_we_i         (di[g].wbw),
            .wb_addr_i       (di[g].wba),
            .dep_rs_o        (dep_rs[g]),
            .dep_rd_o        (dep_rd[g]),
            .fwd_sel_o       (fwd[g]),
            .head_commit_ok_o(hco[g]),
            .head_kill_o     (hk[g]),
            .inflight_full_o (full[g]),
            .issue_ok_o      (iok[g]),
            .inflight_cnt_o  (cnt[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        for (int g = 0; g < 3; g++) di[g] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #2;
        for (int g = 0; g < 3; g++) begin
            chk("rst_iok", iok[g], 0);
            chk("rst_cnt", cnt[g], 0);
            chk("rst_full", full[g], 0);
            chk("rst_fwd", fwd[g], 0);
            chk("rst_hco", hco[g], 0);
        end
        rst_n = 1'b1;
        tick();

        // Same-cycle commit of head ID 3, then dispatch rd=f5.
        di[0].cv = 1; di[0].cid = 3; di[0].hv = 1; di[0].hid = 3; di[0].rd = 5; di[0].rdfp = 1;
        #1;
        chk("commit_same_hco", hco[0], 1);
        chk("commit_same_iok", iok[0], 1);
        tick();
        di[0].cv = 0; di[0].disp = 1;
        #1;
        chk("commit_tab_hco", hco[0], 1);
        chk("commit_tab_iok", iok[0], 1);
        tick();
        di[0].disp = 0;
        #1;
        chk("disp_cnt", cnt[0], 1);
        chk("disp_dep_rd", dep_rd[0], 1);
        chk("disp_hco_clr", hco[0], 0);
        chk("disp_iok", iok[0], 0);

        // Port 1 retires f5 while the head reads rs2=f5.
        di[0].rdfp = 0; di[0].ruse = 3'b010; di[0].rs = {5'd0, 5'd5, 5'd0};
        di[0].wbv = 2'b10; di[0].wbw = 2'b10; di[0].wba = {5'd5, 5'd0};
        #1;
        chk("fwd_p1", fwd[0], 6'b001000);
        chk("fwd_p1_dep_rs", dep_rs[0], 0);
        tick();
        di[0].wbv = 0; di[0].wbw = 0; di[0].wba = 0;
        #1;
        chk("wb_clr_dep_rs", dep_rs[0], 0);
        chk("wb_clr_cnt", cnt[0], 0);

        // Two dispatches, then both ports retire f7 under a head reading rs1=f7.
        di[0].ruse = 0; di[0].disp = 1; di[0].rdfp = 1; di[0].rd = 7;
        tick();
        di[0].rdfp = 0;
        tick();
        di[0].disp = 0; di[0].rdfp = 1;
        #1;
        chk("cnt_two", cnt[0], 2);
        chk("waw_dep_rd", dep_rd[0], 1);
        di[0].wbv = 2'b11; di[0].wbw = 2'b11; di[0].wba = {5'd7, 5'd7};
        di[0].ruse = 3'b001; di[0].rs = {5'd0, 5'd0, 5'd7};
        #1;
        chk("fwd_prio", fwd[0], 6'b000001);
        chk("fwd_prio_dep_rs", dep_rs[0], 0);
        chk("waw_clear_dep_rd", dep_rd[0], 0);
        chk("pop2_full", full[0], 0);
        tick();
        idle();
        #1;
        chk("pop2_cnt", cnt[0], 0);

        // Kill and drop of ID 2 with one op in flight.
        di[0].disp = 1; di[0].rdfp = 1; di[0].rd = 9;
        tick();
        idle();
        di[0].cv = 1; di[0].ck = 1; di[0].cid = 2; di[0].hv = 1; di[0].hid = 2;
        #1;
        chk("kill_same_hk", hk[0], 1);
        chk("kill_same_hco", hco[0], 0);
        chk("kill_same_iok", iok[0], 0);
        tick();
        di[0].cv = 0; di[0].ck = 0; di[0].drop = 1;
        #1;
        chk("kill_tab_hk", hk[0], 1);
        tick();
        di[0].drop = 0;
        #1;
        chk("drop_hk", hk[0], 0);
        chk("drop_cnt", cnt[0], 1);

        // Fill to the limit, then flush while dispatching.
        idle();
        di[0].disp = 1;
        tick(); tick(); tick();
        idle();
        di[0].hv = 1; di[0].rd = 9; di[0].rdfp = 1;
        #1;
        chk("limit_cnt", cnt[0], 4);
        chk("limit_full", full[0], 1);
        chk("sb9_dep_rd", dep_rd[0], 1);
        di[0].wbv = 2'b01;
        #1;
        chk("limit_wb_full", full[0], 0);
        idle();
        di[0].flush = 1; di[0].disp = 1; di[0].rdfp = 1; di[0].rd = 9;
        tick();
        idle();
        #1;
        chk("flush_cnt", cnt[0], 0);
        chk("flush_full", full[0], 0);
        chk("flush_iok", iok[0], 0);
        chk("flush_fwd", fwd[0], 0);
        chk("flush_hk", hk[0], 0);
        di[0].hv = 1; di[0].rd = 9; di[0].rdfp = 1;
        #1;
        chk("flush_dep_rd", dep_rd[0], 0);

        // Asynchronous reset in the middle of a dispatch cycle.
        idle();
        di[0].disp = 1; di[0].rdfp = 1; di[0].rd = 12;
        tick();
        chk("pre_rst_cnt", cnt[0], 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", cnt[0], 0);
        di[0].disp = 0; di[0].hv = 1;
        #1;
        chk("async_rst_dep_rd", dep_rd[0], 0);
        idle();
        rst_n = 1'b1;
        tick();

        // FORWARDING=0: the same retire no longer resolves the source hazard.
        di[1].disp = 1; di[1].rdfp = 1; di[1].rd = 5;
        tick();
        idle();
        di[1].hv = 1; di[1].ruse = 3'b010; di[1].rs = {5'd0, 5'd5, 5'd0};
        di[1].wbv = 2'b10; di[1].wbw = 2'b10; di[1].wba = {5'd5, 5'd0};
        #1;
        chk("nofwd_dep_rs", dep_rs[1], 1);
        chk("nofwd_fwd", fwd[1], 0);
        tick();
        idle();
        #1;
        chk("nofwd_cnt", cnt[1], 0);

        // OUT_OF_ORDER=0: single op in flight, retire and dispatch may overlap.
        di[2].disp = 1;
        tick();
        idle();
        #1;
        chk("ino_full", full[2], 1);
        chk("ino_cnt", cnt[2], 1);
        di[2].disp = 1; di[2].wbv = 2'b01; di[2].cv = 1; di[2].cid = 0; di[2].hv = 1; di[2].hid = 0;
        #1;
        chk("ino_overlap_full", full[2], 0);
        chk("ino_overlap_iok", iok[2], 1);
        tick();
        idle();
        #1;
        chk("ino_overlap_cnt", cnt[2], 1);
        di[2].wbv = 2'b01;
        tick();
        idle();
        #1;
        chk("ino_drain_cnt", cnt[2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
